// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory serving MEM-stage loads and stores. A request is
// captured in IDLE, held for WAIT_STATES cycles, and completed in RESP with a
// one-cycle Done pulse. Loads return sign-extended lane data; stores merge the
// addressed byte lanes into the stored word. Misaligned and read/write
// conflicting requests complete normally but flag Error and perform no store.
//
// Ports:
//   Clk        rising-edge clock
//   Reset      asynchronous active-low reset (control state and outputs only)
//   MemRead    load size: 00 none, 01 word, 10 half, 11 byte
//   MemWrite   store size, same encoding
//   Address    byte address (upper bits beyond the storage size are ignored)
//   WriteData  store data, right-aligned
//   ReadData   registered, sign-extended load result
//   Busy       stall request: request present and not completing
//   Done       one-cycle completion pulse
//   Error      one-cycle pulse with Done for misaligned/conflicting requests
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [1:0]  MemRead,
   input  logic [1:0]  MemWrite,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Busy,
   output logic        Done,
   output logic        Error
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] SZ_WORD = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_BYTE = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_done;
   logic              r_error;
   logic [31:0]       r_rdata;

   // Captured request (data path, not reset)
   logic [1:0]        r_rd;
   logic [1:0]        r_wr;
   logic [AW+1:0]     r_addr;
   logic [31:0]       r_wdata;

   logic [31:0]       r_mem [DEPTH_WORDS];

   logic              w_req;
   logic              w_in_idle;
   logic [1:0]        w_sel_rd;
   logic [1:0]        w_sel_wr;
   logic [AW+1:0]     w_sel_addr;
   logic [31:0]       w_sel_wdata;
   logic [1:0]        w_size;
   logic              w_misal;
   logic              w_err;
   logic [AW-1:0]     w_idx;
   logic [31:0]       w_word;
   logic [3:0]        w_be;
   logic [31:0]       w_wlane;
   logic [31:0]       w_merged;
   logic              w_enter_resp;
   logic              w_we;
   logic              w_unused_addr;

   // Sign-extend the addressed lane of a stored word according to access size.
   function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return {{24{b[7]}}, b};
         SZ_HALF: return {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   assign w_req     = (MemRead != 2'b00) || (MemWrite != 2'b00);
   assign w_in_idle = (r_state == S_IDLE);

   // In IDLE the live inputs are used so that a zero-wait access can complete
   // on the very edge that accepts it; afterwards the captured copy is used.
   assign w_sel_rd    = w_in_idle ? MemRead             : r_rd;
   assign w_sel_wr    = w_in_idle ? MemWrite            : r_wr;
   assign w_sel_addr  = w_in_idle ? Address[AW+1:0]     : r_addr;
   assign w_sel_wdata = w_in_idle ? WriteData           : r_wdata;

   assign w_unused_addr = ^Address[31:AW+2];

   assign w_size = (w_sel_rd != 2'b00) ? w_sel_rd : w_sel_wr;

   always_comb begin
      w_misal = 1'b0;
      case (w_size)
         SZ_WORD: w_misal = (w_sel_addr[1:0] != 2'b00);
         SZ_HALF: w_misal = w_sel_addr[0];
         default: w_misal = 1'b0;
      endcase
   end

   assign w_err  = ((w_sel_rd != 2'b00) && (w_sel_wr != 2'b00)) || w_misal;
   assign w_idx  = w_sel_addr[AW+1:2];
   assign w_word = r_mem[w_idx];

   // Byte enables and lane-replicated store data
   always_comb begin
      w_be    = 4'b1111;
      w_wlane = w_sel_wdata;
      case (w_sel_wr)
         SZ_BYTE: begin
            w_be    = 4'b0001 << w_sel_addr[1:0];
            w_wlane = {4{w_sel_wdata[7:0]}};
         end
         SZ_HALF: begin
            w_be    = w_sel_addr[1] ? 4'b1100 : 4'b0011;
            w_wlane = {2{w_sel_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wlane = w_sel_wdata;
         end
      endcase
   end

   always_comb begin
      w_merged = w_word;
      for (int i = 0; i < 4; i++) begin
         if (w_be[i]) w_merged[8*i +: 8] = w_wlane[8*i +: 8];
      end
   end

   assign w_enter_resp = (w_in_idle && w_req && (WAIT_STATES == 0)) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd0));

   // Commit happens on the edge leaving RESP; an async reset forces IDLE first,
   // so an aborted access can never reach this write.
   assign w_we = (r_state == S_RESP) && (w_sel_wr != 2'b00) && !w_err;

   // Control FSM and registered outputs
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_rdata <= 32'd0;
      end else begin
         r_done  <= w_enter_resp;
         r_error <= w_enter_resp && w_err;
         if (w_enter_resp && (w_err || (w_sel_rd != 2'b00))) begin
            r_rdata <= w_err ? 32'd0 : f_load_ext(w_word, w_sel_rd, w_sel_addr[1:0]);
         end
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                  r_cnt   <= CNT_INIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) r_state <= S_RESP;
               else               r_cnt   <= r_cnt - 4'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Request capture at acceptance
   always_ff @(posedge Clk) begin
      if (w_in_idle && w_req) begin
         r_rd    <= MemRead;
         r_wr    <= MemWrite;
         r_addr  <= Address[AW+1:0];
         r_wdata <= WriteData;
      end
   end

   // Storage (never reset)
   always_ff @(posedge Clk) begin
      if (w_we) r_mem[w_idx] <= w_merged;
   end

   assign ReadData = r_rdata;
   assign Done     = r_done;
   assign Error    = r_error;
   assign Busy     = w_req && !r_done;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mr [2];
   logic [1:0]  mw [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic [31:0] rdata [2];
   logic        busy [2];
   logic        done [2];
   logic        err  [2];

   always #5 clk = ~clk;

   // Index 0: WAIT_STATES = 2, index 1: WAIT_STATES = 0
   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_dut_ws2 (
      .Clk(clk), .Reset(rst_n), .MemRead(mr[0]), .MemWrite(mw[0]),
      .Address(ad[0]), .WriteData(wd[0]), .ReadData(rdata[0]),
      .Busy(busy[0]), .Done(done[0]), .Error(err[0]));

   data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut_ws0 (
      .Clk(clk), .Reset(rst_n), .MemRead(mr[1]), .MemWrite(mw[1]),
      .Address(ad[1]), .WriteData(wd[1]), .ReadData(rdata[1]),
      .Busy(busy[1]), .Done(done[1]), .Error(err[1]));

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          lat;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] last_rd [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs(input int d);
      mr[d] = 2'b00; mw[d] = 2'b00; ad[d] = 32'd0; wd[d] = 32'd0;
   endtask

   // Drive one access just after a rising edge, push its expected outcome,
   // then wait (bounded) for Done, pop and compare. Inputs are released right
   // after the edge following Done, which is when the pipeline advances.
   task automatic access(input int d, input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] load_val, input logic exp_er,
                         input string tag,
                         output int unsigned t_start, output int unsigned t_done);
      exp_t e;
      int   n;
      bit   got;
      e.er  = exp_er;
      e.lat = (d == 0) ? 3 : 1;
      if (exp_er)          e.rd = 32'd0;
      else if (rd == 2'b00) e.rd = last_rd[d];
      else                  e.rd = load_val;
      sb.push_back(e);
      last_rd[d] = e.rd;

      mr[d] = rd; mw[d] = wr; ad[d] = a; wd[d] = w;
      t_start = cyc;
      n   = 0;
      got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         if (done[d]) got = 1;
         else begin
            chk({tag, "_busy"}, 32'(busy[d]), 32'd1);
            n++;
         end
      end
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      if (got) begin
         chk({tag, "_rdata"}, rdata[d], e.rd);
         chk({tag, "_error"}, 32'(err[d]), 32'(e.er));
         chk({tag, "_busy_at_done"}, 32'(busy[d]), 32'd0);
      end
      t_done = cyc;
      @(posedge clk);
      #1;
      idle_inputs(0);
      idle_inputs(1);
   endtask

   initial begin
      int unsigned ts, td, ts1, td1, ts2, td2;
      last_rd[0] = 32'd0;
      last_rd[1] = 32'd0;
      idle_inputs(0);
      idle_inputs(1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rdata", rdata[0], 32'd0);
      chk("reset_done",  32'(done[0]), 32'd0);
      chk("reset_error", 32'(err[0]), 32'd0);
      chk("reset_busy",  32'(busy[0]), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Word store / load
      access(0, 2'b00, 2'b01, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, "st_word_10", ts, td);
      access(0, 2'b01, 2'b00, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "ld_word_10", ts, td);
      // Address wraps modulo 4 KiB
      access(0, 2'b01, 2'b00, 32'h1010, 32'd0, 32'hDEADBEEF, 1'b0, "ld_word_wrap", ts, td);

      // Byte and half lanes
      access(0, 2'b00, 2'b01, 32'h20, 32'h11223344, 32'd0, 1'b0, "st_word_20", ts, td);
      access(0, 2'b00, 2'b11, 32'h22, 32'h00000080, 32'd0, 1'b0, "st_byte_22", ts, td);
      access(0, 2'b01, 2'b00, 32'h20, 32'd0, 32'h11803344, 1'b0, "ld_word_20", ts, td);
      access(0, 2'b11, 2'b00, 32'h22, 32'd0, 32'hFFFFFF80, 1'b0, "ld_byte_22", ts, td);
      access(0, 2'b11, 2'b00, 32'h23, 32'd0, 32'h00000011, 1'b0, "ld_byte_23", ts, td);
      access(0, 2'b10, 2'b00, 32'h20, 32'd0, 32'h00003344, 1'b0, "ld_half_20", ts, td);
      access(0, 2'b10, 2'b00, 32'h22, 32'd0, 32'h00001180, 1'b0, "ld_half_22", ts, td);
      // Store-only access must leave ReadData untouched
      access(0, 2'b00, 2'b10, 32'h30, 32'h0000BEEF, 32'd0, 1'b0, "st_half_30", ts, td);
      access(0, 2'b10, 2'b00, 32'h30, 32'd0, 32'hFFFFBEEF, 1'b0, "ld_half_30", ts, td);

      // Misaligned accesses
      access(0, 2'b01, 2'b00, 32'h21, 32'd0, 32'd0, 1'b1, "ld_word_misal", ts, td);
      access(0, 2'b01, 2'b00, 32'h20, 32'd0, 32'h11803344, 1'b0, "ld_word_20b", ts, td);
      access(0, 2'b00, 2'b10, 32'h23, 32'h0000AAAA, 32'd0, 1'b1, "st_half_misal", ts, td);
      access(0, 2'b01, 2'b00, 32'h20, 32'd0, 32'h11803344, 1'b0, "ld_word_20c", ts, td);

      // Read/write conflict: error, no store
      access(0, 2'b01, 2'b01, 32'h10, 32'h00000000, 32'd0, 1'b1, "conflict", ts, td);
      access(0, 2'b01, 2'b00, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "ld_after_conf", ts, td);

      // Reset during WAIT aborts the store
      access(0, 2'b00, 2'b01, 32'h40, 32'h12345678, 32'd0, 1'b0, "st_word_40", ts, td);
      access(0, 2'b01, 2'b00, 32'h40, 32'd0, 32'h12345678, 1'b0, "ld_word_40", ts, td);
      mr[0] = 2'b00; mw[0] = 2'b01; ad[0] = 32'h40; wd[0] = 32'hCAFEF00D;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_rdata", rdata[0], 32'd0);
      chk("abort_done",  32'(done[0]), 32'd0);
      chk("abort_error", 32'(err[0]), 32'd0);
      chk("abort_busy",  32'(busy[0]), 32'd1);
      idle_inputs(0);
      @(negedge clk);
      rst_n = 1'b1;
      last_rd[0] = 32'd0;
      @(posedge clk);
      #1;
      access(0, 2'b01, 2'b00, 32'h40, 32'd0, 32'h12345678, 1'b0, "ld_after_abort", ts, td);

      // Zero wait states, back-to-back loads
      access(1, 2'b00, 2'b01, 32'h08, 32'hA5A50001, 32'd0, 1'b0, "ws0_st", ts, td);
      access(1, 2'b01, 2'b00, 32'h08, 32'd0, 32'hA5A50001, 1'b0, "ws0_ld_word", ts1, td1);
      access(1, 2'b11, 2'b00, 32'h0B, 32'd0, 32'hFFFFFFA5, 1'b0, "ws0_ld_byte", ts2, td2);
      chk("ws0_first_done_cycle",  32'(td1 - ts1), 32'd1);
      chk("ws0_second_done_cycle", 32'(td2 - ts1), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving the pipeline's MEM-stage load/store requests. Accepts the 2-bit MemRead/MemWrite size encodings and an address/write-data pair, and inserts a programmable number of wait states. It returns sign-extended load data, commits stores with byte-lane masking, and drives a Busy stall toward the hazard unit until the access completes.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two)
- WAIT_STATES, 2, extra cycles between request acceptance and completion (0..15)

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- MemRead  input  2  load request/size: 00 none, 01 word, 10 half, 11 byte
- MemWrite  input  2  store request/size, same encoding
- Address  input  32  byte address
- WriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ReadData  output  32  load result, sign-extended, registered
- Busy  output  1  stall request; high while a request is present and not completing
- Done  output  1  one-cycle completion pulse
- Error  output  1  one-cycle pulse, coincident with Done, for a misaligned or conflicting request

## Operation
- Request present = (MemRead != 0) or (MemWrite != 0). The requester holds all inputs stable from acceptance until Done.
- FSM states:
  - IDLE: on request present, capture the request and go to WAIT (or RESP if WAIT_STATES = 0).
  - WAIT: count down WAIT_STATES cycles, then go to RESP.
  - RESP: assert Done for one cycle, then go to IDLE.
- Busy = request present AND NOT Done (combinational). The hazard unit stalls the PC and all pipeline registers while Busy is high.
- Word index = Address[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4 bytes.
- Lanes are little-endian: byte lane = Address[1:0], half lane = Address[1].
- Store commits on the Clk edge that leaves RESP. Only the addressed lanes change.
- Load: ReadData is updated on entry to RESP with the lane data sign-extended to 32 bits.
- Misaligned access: half with Address[0]=1, or word with Address[1:0]≠0.
  - Completes normally through WAIT/RESP.
  - Error=1 with Done. No store. ReadData is loaded with 0.
- MemRead and MemWrite both nonzero: treated as an error the same way. No store, ReadData is loaded with 0.
- ReadData holds its value across stores and idle cycles. It changes only on a load or error completion.
- Storage is not cleared by Reset. Contents are undefined until written. Benches initialise storage by hierarchical preload.

## Timing
- Reset low (asynchronous): FSM → IDLE, wait counter = 0, ReadData = 0, Done = 0, Error = 0. Busy follows its combinational definition.
- Latency is WAIT_STATES + 1 cycles from the first cycle a request is present in IDLE to the Done cycle.
  - WAIT_STATES = 2: request at cycle 0, Done at cycle 3, Busy high in cycles 0–2.
- Throughput is one access per WAIT_STATES + 2 cycles, because one IDLE cycle is always taken between accesses.
- Back-to-back requests: the pipeline advances on Done. The new request is seen in IDLE on the next cycle and accepted immediately.
- Reset during WAIT or RESP: the access is aborted and no store occurs, even if Reset is released before what would have been the commit edge. The requester re-issues the access after reset.
- Input changes during WAIT/RESP are a protocol violation. The captured request is used regardless.

## Test plan
- Word store then load, WAIT_STATES=2: store 0xDEADBEEF @0x10 → Done at cycle 3 with Busy high in cycles 0–2. Word load @0x10 → ReadData=0xDEADBEEF at Done.
- Byte and half lanes: word 0x11223344 @0x20.
  - Byte store 0x80 @0x22 → word becomes 0x11803344.
  - Byte load @0x22 → 0xFFFFFF80.
  - Half load @0x20 → 0x00003344.
- Misaligned: word load @0x21 → Done and Error together, ReadData=0. Half store @0x23 leaves memory unchanged.
- Conflict: MemRead=01 and MemWrite=01 together → Error with Done, no store.
- WAIT_STATES=0: request at cycle 0 → Done at cycle 1. Two back-to-back loads complete at cycles 1 and 3.
- Reset asserted during WAIT of a store to @0x40 → outputs return to 0 immediately. The later load @0x40 returns the pre-store value.
